// File: rtl/filter_error_monitor.sv
// Compares filter output samples against delayed reference samples held in a FIFO,
// producing per-sample error plus running count, squared-error/reference sums and peak error.
module filter_error_monitor #(
    parameter int DW    = 16,
    parameter int DEPTH = 32,
    parameter int CNT_W = 32,
    parameter int ACC_W = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      ref_valid_i,
    input  logic [DW-1:0]             ref_i,
    input  logic                      data_valid_i,
    input  logic [DW-1:0]             data_i,
    output logic                      error_valid_o,
    output logic signed [DW:0]        error_o,
    output logic [CNT_W-1:0]          sample_cnt_o,
    output logic [ACC_W-1:0]          err2_acc_o,
    output logic [ACC_W-1:0]          ref2_acc_o,
    output logic [DW-1:0]             peak_err_o,
    output logic [$clog2(DEPTH):0]    fifo_level_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]          mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            level_q, level_d;
    logic                   overflow_q, underflow_q;

    logic                   s1_valid_q;
    logic signed [DW:0]     err_q, err_d;
    logic signed [DW-1:0]   s1_ref_q;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]       err2_q, err2_d, ref2_q, ref2_d;
    logic [DW-1:0]          peak_q, peak_d;

    logic                   fifo_full, fifo_empty, push, pop;
    logic [DW-1:0]          pop_ref;
    logic signed [2*DW+1:0] err_ext, err_sq;
    logic signed [2*DW-1:0] ref_ext, ref_sq;
    logic [DW:0]            abs_err;
    logic [ACC_W:0]         err2_sum, ref2_sum;

    assign fifo_full  = (level_q == (AW+1)'(DEPTH));
    assign fifo_empty = (level_q == '0);
    assign pop        = data_valid_i && !fifo_empty;
    // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
    assign push       = ref_valid_i && (!fifo_full || pop);
    assign pop_ref    = mem_q[rd_ptr_q];
    assign err_d      = $signed({pop_ref[DW-1], pop_ref}) - $signed({data_i[DW-1], data_i});

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Squares are formed at full width so the top error bit (|err| up to 2**DW-1) is never lost.
    assign err_ext  = (2*DW+2)'(err_q);
    assign err_sq   = err_ext * err_ext;
    assign ref_ext  = (2*DW)'(s1_ref_q);
    assign ref_sq   = ref_ext * ref_ext;
    assign abs_err  = err_q[DW] ? $unsigned(-err_q) : $unsigned(err_q);
    assign err2_sum = {1'b0, err2_q} + (ACC_W+1)'($unsigned(err_sq));
    assign ref2_sum = {1'b0, ref2_q} + (ACC_W+1)'($unsigned(ref_sq));

    always_comb begin
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        err2_d = err2_sum[ACC_W] ? {ACC_W{1'b1}} : err2_sum[ACC_W-1:0];
        ref2_d = ref2_sum[ACC_W] ? {ACC_W{1'b1}} : ref2_sum[ACC_W-1:0];
        peak_d = (abs_err > {1'b0, peak_q}) ? abs_err[DW-1:0] : peak_q;
    end

    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            mem_q[wr_ptr_q] <= ref_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            err_q       <= '0;
            s1_ref_q    <= '0;
            cnt_q       <= '0;
            err2_q      <= '0;
            ref2_q      <= '0;
            peak_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            if (ref_valid_i && fifo_full && !pop) overflow_q  <= 1'b1;
            if (data_valid_i && fifo_empty)       underflow_q <= 1'b1;
            s1_valid_q <= pop;
            if (pop) begin
                err_q    <= err_d;
                s1_ref_q <= pop_ref;
            end
            if (s1_valid_q) begin
                cnt_q  <= cnt_d;
                err2_q <= err2_d;
                ref2_q <= ref2_d;
                peak_q <= peak_d;
            end
        end
    end

    assign error_valid_o = s1_valid_q;
    assign error_o       = err_q;
    assign sample_cnt_o  = cnt_q;
    assign err2_acc_o    = err2_q;
    assign ref2_acc_o    = ref2_q;
    assign peak_err_o    = peak_q;
    assign fifo_level_o  = level_q;
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_filter_error_monitor.sv
// Self-checking bench for filter_error_monitor (DW=16, DEPTH=4) against a queue-based reference model.
module tb_filter_error_monitor;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic               ref_valid;
    logic [15:0]        ref_in;
    logic               data_valid;
    logic [15:0]        data_in;
    logic               error_valid;
    logic signed [16:0] err_out;
    logic [31:0]        sample_cnt;
    logic [63:0]        err2_acc;
    logic [63:0]        ref2_acc;
    logic [15:0]        peak_err;
    logic [2:0]         fifo_level;
    logic               overflow;
    logic               underflow;

    int checks = 0;
    int errors = 0;

    filter_error_monitor #(.DW(16), .DEPTH(4), .CNT_W(32), .ACC_W(64)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .ref_valid_i(ref_valid), .ref_i(ref_in),
        .data_valid_i(data_valid), .data_i(data_in),
        .error_valid_o(error_valid), .error_o(err_out),
        .sample_cnt_o(sample_cnt), .err2_acc_o(err2_acc), .ref2_acc_o(ref2_acc),
        .peak_err_o(peak_err), .fifo_level_o(fifo_level),
        .overflow_o(overflow), .underflow_o(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: queue of pending references plus the expected observable state.
    int          q[$];
    bit          m_ev;
    int          m_err;
    bit          m_pend;
    int          m_perr, m_pref;
    logic [31:0] m_cnt;
    logic [63:0] m_e2, m_r2;
    int          m_peak;
    bit          m_ovf, m_unf;

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? {64{1'b1}} : s[63:0];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ev = 0; m_err = 0; m_pend = 0; m_perr = 0; m_pref = 0;
        m_cnt = '0; m_e2 = '0; m_r2 = '0; m_peak = 0; m_ovf = 0; m_unf = 0;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Drive one cycle of inputs, let one rising edge pass, then advance the model.
    task automatic step(input bit rv, input int r, input bit dv, input int d, input bit clr);
        bit full, empty, pop, push;
        int pr;
        ref_valid = rv; ref_in = r[15:0]; data_valid = dv; data_in = d[15:0]; clear = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            model_reset();
        end else begin
            if (m_pend) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                m_e2 = sat_add(m_e2, 64'(longint'(m_perr) * longint'(m_perr)));
                m_r2 = sat_add(m_r2, 64'(longint'(m_pref) * longint'(m_pref)));
                if (iabs(m_perr) > m_peak) m_peak = iabs(m_perr);
            end
            m_pend = 0;
            m_ev   = 0;
            full   = (q.size() == 4);
            empty  = (q.size() == 0);
            pop    = dv && !empty;
            push   = rv && (!full || pop);
            if (pop) begin
                pr = q.pop_front();
                m_err = pr - d; m_ev = 1; m_pend = 1; m_perr = m_err; m_pref = pr;
            end
            if (push) q.push_back(r);
            if (rv && full && !pop) m_ovf = 1;
            if (dv && empty) m_unf = 1;
        end
        ref_valid = 0; data_valid = 0; clear = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear = 0; ref_valid = 0; data_valid = 0; ref_in = '0; data_in = '0;
        #1;
        checks++; if (error_valid !== 1'b0) begin errors++; $display("FAIL reset_ev got %0b want 0", error_valid); end
        checks++; if (err_out !== 17'd0)    begin errors++; $display("FAIL reset_err got %0d want 0", err_out); end
        checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", sample_cnt); end
        checks++; if (err2_acc !== 64'd0)   begin errors++; $display("FAIL reset_e2 got %0d want 0", err2_acc); end
        checks++; if (ref2_acc !== 64'd0)   begin errors++; $display("FAIL reset_r2 got %0d want 0", ref2_acc); end
        checks++; if (peak_err !== 16'd0)   begin errors++; $display("FAIL reset_peak got %0d want 0", peak_err); end
        checks++; if (fifo_level !== 3'd0)  begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        checks++; if (underflow !== 1'b0)   begin errors++; $display("FAIL reset_unf got %0b want 0", underflow); end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_first_push();
        step(1, 55, 0, 0, 0);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL first_push_level got %0d want 1", fifo_level); end
        $display("test_first_push level=%0d", fifo_level);
    endtask

    task automatic test_basic();
        int refs[3] = '{100, -200, 300};
        int dat[3]  = '{90, -200, 310};
        int exp_e[3] = '{10, 0, -10};
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, refs[i], 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, dat[i], 0);
            checks++; if (error_valid !== 1'b1) begin errors++; $display("FAIL basic_ev%0d got %0b want 1", i, error_valid); end
            checks++; if (err_out !== 17'(exp_e[i])) begin errors++; $display("FAIL basic_err%0d got %0d want %0d", i, err_out, exp_e[i]); end
            $display("test_basic pop %0d error=%0d", i, err_out);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++; if (error_valid !== 1'b0)     begin errors++; $display("FAIL basic_ev_idle got %0b want 0", error_valid); end
        checks++; if (sample_cnt !== 32'd3)     begin errors++; $display("FAIL basic_cnt got %0d want 3", sample_cnt); end
        checks++; if (err2_acc !== 64'd200)     begin errors++; $display("FAIL basic_e2 got %0d want 200", err2_acc); end
        checks++; if (ref2_acc !== 64'd140000)  begin errors++; $display("FAIL basic_r2 got %0d want 140000", ref2_acc); end
        checks++; if (peak_err !== 16'd10)      begin errors++; $display("FAIL basic_peak got %0d want 10", peak_err); end
    endtask

    task automatic test_extreme();
        step(0, 0, 0, 0, 1);
        step(1, 32767, 0, 0, 0);
        step(0, 0, 1, -32768, 0);
        checks++; if (err_out !== 17'd65535) begin errors++; $display("FAIL extreme_err got %0d want 65535", err_out); end
        step(0, 0, 0, 0, 0);
        checks++; if (peak_err !== 16'd65535) begin errors++; $display("FAIL extreme_peak got %0d want 65535", peak_err); end
        checks++; if (err2_acc !== 64'd4294836225) begin errors++; $display("FAIL extreme_e2 got %0d want 4294836225", err2_acc); end
        checks++; if (ref2_acc !== 64'd1073676289) begin errors++; $display("FAIL extreme_r2 got %0d want 1073676289", ref2_acc); end
        $display("test_extreme error=%0d peak=%0d", err_out, peak_err);
    endtask

    task automatic test_overflow();
        int refs[5];
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            refs[i] = rnd16();
            step(1, refs[i], 0, 0, 0);
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
        checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            checks++; if (error_valid !== 1'b1 || err_out !== 17'(refs[i])) begin
                errors++; $display("FAIL ovf_pop%0d got v=%0b e=%0d want v=1 e=%0d", i, error_valid, err_out, refs[i]);
            end
            $display("test_overflow pop %0d ref=%0d", i, err_out);
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drain got %0d want 0", fifo_level); end
    endtask

    task automatic test_stream();
        step(0, 0, 0, 0, 1);
        step(1, rnd16(), 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            step(1, rnd16(), 1, rnd16(), 0);
            checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL stream_level%0d got %0d want 1", i, fifo_level); end
            checks++; if (error_valid !== 1'b1 || err_out !== 17'(m_err)) begin
                errors++; $display("FAIL stream_err%0d got v=%0b e=%0d want v=1 e=%0d", i, error_valid, err_out, m_err);
            end
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++; if (sample_cnt !== 32'd100)      begin errors++; $display("FAIL stream_cnt got %0d want 100", sample_cnt); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL stream_flags got %0b%0b want 00", overflow, underflow); end
        checks++; if (err2_acc !== m_e2)           begin errors++; $display("FAIL stream_e2 got %0d want %0d", err2_acc, m_e2); end
        checks++; if (ref2_acc !== m_r2)           begin errors++; $display("FAIL stream_r2 got %0d want %0d", ref2_acc, m_r2); end
        checks++; if (peak_err !== 16'(m_peak))    begin errors++; $display("FAIL stream_peak got %0d want %0d", peak_err, m_peak); end
        $display("test_stream cnt=%0d peak=%0d", sample_cnt, peak_err);
    endtask

    task automatic test_underflow();
        step(0, 0, 0, 0, 1);
        step(1, 77, 1, 5, 0);
        checks++; if (underflow !== 1'b1)   begin errors++; $display("FAIL unf_flag got %0b want 1", underflow); end
        checks++; if (error_valid !== 1'b0) begin errors++; $display("FAIL unf_ev got %0b want 0", error_valid); end
        checks++; if (fifo_level !== 3'd1)  begin errors++; $display("FAIL unf_level got %0d want 1", fifo_level); end
        step(0, 0, 0, 0, 0);
        checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL unf_cnt got %0d want 0", sample_cnt); end
        $display("test_underflow unf=%0b level=%0d", underflow, fifo_level);
    endtask

    task automatic test_random();
        bit rv, dv, clr;
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            rv  = ($urandom_range(0, 99) < 55);
            dv  = ($urandom_range(0, 99) < 50);
            clr = ($urandom_range(0, 99) < 2);
            step(rv, rnd16(), dv, rnd16(), clr);
            checks++; if (error_valid !== m_ev)        begin errors++; $display("FAIL rnd_ev%0d got %0b want %0b", i, error_valid, m_ev); end
            checks++; if (err_out !== 17'(m_err))      begin errors++; $display("FAIL rnd_err%0d got %0d want %0d", i, err_out, m_err); end
            checks++; if (fifo_level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level%0d got %0d want %0d", i, fifo_level, q.size()); end
            checks++; if (sample_cnt !== m_cnt)        begin errors++; $display("FAIL rnd_cnt%0d got %0d want %0d", i, sample_cnt, m_cnt); end
            checks++; if (err2_acc !== m_e2)           begin errors++; $display("FAIL rnd_e2%0d got %0d want %0d", i, err2_acc, m_e2); end
            checks++; if (ref2_acc !== m_r2)           begin errors++; $display("FAIL rnd_r2%0d got %0d want %0d", i, ref2_acc, m_r2); end
            checks++; if (peak_err !== 16'(m_peak))    begin errors++; $display("FAIL rnd_peak%0d got %0d want %0d", i, peak_err, m_peak); end
            checks++; if (overflow !== m_ovf || underflow !== m_unf) begin
                errors++; $display("FAIL rnd_flags%0d got %0b%0b want %0b%0b", i, overflow, underflow, m_ovf, m_unf);
            end
        end
        $display("test_random cnt=%0d level=%0d", sample_cnt, fifo_level);
    endtask

    task automatic test_abort_reset();
        step(0, 0, 0, 0, 1);
        step(1, 1000, 0, 0, 0);
        step(1, -1000, 0, 0, 0);
        step(0, 0, 1, 3, 0);
        step(0, 0, 1, 4, 0);
        #2 rst = 1;
        #1;
        checks++; if (error_valid !== 1'b0 || err_out !== 17'd0) begin errors++; $display("FAIL arst_err got v=%0b e=%0d want 0 0", error_valid, err_out); end
        checks++; if (sample_cnt !== 32'd0 || err2_acc !== 64'd0 || ref2_acc !== 64'd0 || peak_err !== 16'd0) begin
            errors++; $display("FAIL arst_metrics got %0d %0d %0d %0d want 0", sample_cnt, err2_acc, ref2_acc, peak_err);
        end
        checks++; if (fifo_level !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL arst_fifo got %0d %0b %0b want 0", fifo_level, overflow, underflow);
        end
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            checks++; if (error_valid !== 1'b0 || sample_cnt !== 32'd0) begin
                errors++; $display("FAIL arst_after%0d got v=%0b cnt=%0d want 0 0", i, error_valid, sample_cnt);
            end
        end
        $display("test_abort_reset cnt=%0d", sample_cnt);
    endtask

    task automatic test_abort_clear();
        step(0, 0, 0, 0, 1);
        step(1, 2000, 0, 0, 0);
        step(1, -2000, 0, 0, 0);
        step(0, 0, 1, 7, 0);
        step(0, 0, 1, 8, 0);
        step(1, 9, 1, 0, 1);
        checks++; if (error_valid !== 1'b0 || err_out !== 17'd0) begin errors++; $display("FAIL clr_err got v=%0b e=%0d want 0 0", error_valid, err_out); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL clr_level got %0d want 0", fifo_level); end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0);
            checks++; if (error_valid !== 1'b0 || sample_cnt !== 32'd0 || err2_acc !== 64'd0 || ref2_acc !== 64'd0 || peak_err !== 16'd0) begin
                errors++; $display("FAIL clr_after%0d got v=%0b cnt=%0d e2=%0d r2=%0d pk=%0d want 0", i, error_valid, sample_cnt, err2_acc, ref2_acc, peak_err);
            end
        end
        $display("test_abort_clear cnt=%0d level=%0d", sample_cnt, fifo_level);
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_basic();
        test_extreme();
        test_overflow();
        test_stream();
        test_underflow();
        test_random();
        test_abort_reset();
        test_abort_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_error_monitor.md
FILTER_ERROR_MONITOR -- requirements
Module: filter_error_monitor

Parameters
REQ-001 The block SHALL have parameter DW, default 16, meaning sample width of reference and filter output, signed two's complement.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning reference FIFO depth; a power of two, at least 4.
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning sample counter width.
REQ-004 The block SHALL have parameter ACC_W, default 64, meaning squared-sum accumulator width; ACC_W is at least 2*DW+2.

Interface
REQ-005 The block SHALL have port clk_i, input, 1 bit: single clock; one clock; all logic on rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset is asynchronous and active-high.
REQ-007 The block SHALL have port clear_i, input, 1 bit: synchronous clear of FIFO, pipeline, metrics and flags.
REQ-008 The block SHALL have ports ref_valid_i, input, 1 bit, and ref_i, input, DW bits: reference sample, pushed at filter-input time.
REQ-009 The block SHALL have ports data_valid_i, input, 1 bit, and data_i, input, DW bits: filter output sample; pops one reference.
REQ-010 The block SHALL have ports error_valid_o, output, 1 bit, and error_o, output, DW+1 bits signed: per-sample error ref minus data.
REQ-011 The block SHALL have port sample_cnt_o, output, CNT_W bits: number of compared samples.
REQ-012 The block SHALL have ports err2_acc_o and ref2_acc_o, output, ACC_W bits each: sum of error squared and sum of reference squared.
REQ-013 The block SHALL have port peak_err_o, output, DW bits unsigned: maximum absolute error.
REQ-014 The block SHALL have port fifo_level_o, output, log2(DEPTH)+1 bits: current FIFO occupancy.
REQ-015 The block SHALL have ports overflow_o and underflow_o, output, 1 bit each: sticky error flags.

Function
REQ-016 ref_valid_i=1 with FIFO not full SHALL write ref_i into the FIFO at that edge.
REQ-017 data_valid_i=1 with FIFO not empty SHALL pop the oldest reference in the same cycle.
REQ-018 A pop SHALL register error_o = sign-extended ref minus sign-extended data_i, with error_valid_o=1, exactly 1 cycle after data_valid_i.
REQ-019 error_valid_o SHALL be 1 for exactly one cycle per successful pop, and 0 otherwise; error_o SHALL hold its last value while error_valid_o=0.
REQ-020 sample_cnt_o, err2_acc_o, ref2_acc_o and peak_err_o SHALL update exactly 2 cycles after data_valid_i, from the stage-1 error and the popped reference.
REQ-021 The accumulators SHALL add error*error and ref*ref as unsigned values, and SHALL saturate at all-ones with no wrap.
REQ-022 sample_cnt_o SHALL saturate at 2**CNT_W-1.
REQ-023 peak_err_o SHALL be replaced when |error_o| is strictly greater than its current value; |error| of at most 2**DW-1 SHALL fit in DW bits.
REQ-024 Simultaneous push and pop on a non-empty FIFO SHALL both occur, leaving the level unchanged; this SHALL hold even when the FIFO is full.
REQ-025 Push on a full FIFO without a pop SHALL discard ref_i, leave the FIFO unchanged, and set overflow_o.
REQ-026 data_valid_i on an empty FIFO SHALL produce no error_valid_o and no metric update, and SHALL set underflow_o; there is no bypass, even if ref_valid_i is 1 in the same cycle, in which case the push still occurs.
REQ-027 overflow_o and underflow_o SHALL stay set until clear_i or rst_i.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; fifo_level_o SHALL range from 0 to DEPTH.
REQ-029 clear_i SHALL take priority over a push or pop in the same cycle.
REQ-030 clear_i SHALL empty the FIFO, cancel the in-flight stage-1 and stage-2 operations, zero all metrics and flags, and drive error_valid_o=0 on the next cycle.

Reset
REQ-031 rst_i=1 SHALL immediately, without a clock, drive error_valid_o=0, error_o=0, sample_cnt_o=0, err2_acc_o=0, ref2_acc_o=0, peak_err_o=0, fifo_level_o=0, overflow_o=0 and underflow_o=0.
REQ-032 Reset asserted mid-stream SHALL discard FIFO contents and in-flight pipeline data.
REQ-033 The first push SHALL be accepted on the first rising edge after rst_i deasserts.

Verification
REQ-034 Push refs 100, -200, 300; 3 cycles later give data_valid_i with data 90, -200, 310 -> error_o 10, 0, -10 on consecutive cycles; final sample_cnt_o=3, err2_acc_o=200, ref2_acc_o=140000, peak_err_o=10.
REQ-035 DW=16: push ref 32767, pop with data -32768 -> error_o=65535, peak_err_o=65535, err2_acc_o=4294836225.
REQ-036 DEPTH=4: push 5 refs with no pop -> fifo_level_o=4, overflow_o=1; the 4 pops after that return the first 4 refs in order.
REQ-037 Push and pop every cycle for 100 cycles after a single preload -> fifo_level_o stays 1, sample_cnt_o=100, no flags set, with pointer wrap exercised.
REQ-038 data_valid_i with an empty FIFO and ref_valid_i=1 in the same cycle -> underflow_o=1, no error_valid_o, fifo_level_o=1 afterwards.
REQ-039 Assert rst_i asynchronously, then separately clear_i, both with 2 pops in flight -> all outputs 0 and no error_valid_o pulse afterwards.
